seg_scan_decoder: RTL and testbench

- Monitor-side decoder for the multiplexed 8-digit seven-segment bus driven by the stopwatch top level: dp, anode and cathode outputs.
- Watches the scanned anode/cathode/dp lines, waits for each digit slot to settle and decodes the cathode pattern back to a nibble.
- Assembles a full frame of digits and pulses when every digit has been seen.
- Used in benches as a self-checking display receiver; also synthesisable for on-board readback.

---
 rtl/seg_scan_decoder.sv | 196 +++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed seven-segment scan bus: waits for each anode dwell to settle,
// decodes the cathode glyph into its digit slot and pulses frame_done once every slot is seen.
// Hex glyphs A-F are decoded only when SEG_DECODE_HEX_EN is defined.
module seg_scan_decoder #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  parameter int unsigned CAT_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              cat_in,
  input  logic                    dp_in,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   invalid,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    scan_error
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DIG_W  = NIB_W * NUM_DIGITS;
  localparam bit          AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam bit          CAT_INV = (CAT_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0]      SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]      CAPTURE_AT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE    = AN_INV ? '1 : '0;
  localparam logic [DIG_W-1:0]      DIGITS_RST = {NUM_DIGITS{4'hF}};

  typedef struct packed {
    logic [NIB_W-1:0] nib;
    logic             blank;
    logic             inv;
  } glyph_t;

  // Active-high g..a pattern to nibble; unknown patterns flag invalid.
  function automatic glyph_t decode_seg(input logic [SEG_W-1:0] seg);
    glyph_t g;
    g.nib   = 4'hF;
    g.blank = 1'b0;
    g.inv   = 1'b0;
    case (seg)
      7'h3F: g.nib = 4'h0;
      7'h06: g.nib = 4'h1;
      7'h5B: g.nib = 4'h2;
      7'h4F: g.nib = 4'h3;
      7'h66: g.nib = 4'h4;
      7'h6D: g.nib = 4'h5;
      7'h7D: g.nib = 4'h6;
      7'h07: g.nib = 4'h7;
      7'h7F: g.nib = 4'h8;
      7'h6F: g.nib = 4'h9;
      7'h00: g.blank = 1'b1;
`ifdef SEG_DECODE_HEX_EN
      7'h77: g.nib = 4'hA;
      7'h7C: g.nib = 4'hB;
      7'h39: g.nib = 4'hC;
      7'h5E: g.nib = 4'hD;
      7'h79: g.nib = 4'hE;
      7'h71: g.nib = 4'hF;
`endif
      default: g.inv = 1'b1;
    endcase
    return g;
  endfunction

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  captured_q, captured_d;
  logic [DIG_W-1:0]      digits_q, digits_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [NUM_DIGITS-1:0] inv_q, inv_d;
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  scan_error_q, scan_error_d;

  logic [NUM_DIGITS-1:0] an_norm_c;
  logic [SEG_W-1:0]      seg_norm_c;
  logic                  dp_norm_c;
  logic                  stable_c;
  logic                  any_c;
  logic                  onehot_c;
  logic                  capture_pt_c;
  logic                  capture_c;
  logic                  multi_c;
  glyph_t                glyph_c;

  assign an_norm_c    = AN_INV  ? ~an_in  : an_in;
  assign seg_norm_c   = CAT_INV ? ~cat_in : cat_in;
  assign dp_norm_c    = CAT_INV ? ~dp_in  : dp_in;
  assign stable_c     = (an_in == an_q);
  assign any_c        = |an_norm_c;
  assign onehot_c     = any_c && ((an_norm_c & (an_norm_c - NUM_DIGITS'(1))) == '0);
  assign capture_pt_c = stable_c && (cnt_q == CAPTURE_AT) && !captured_q;
  assign capture_c    = capture_pt_c && onehot_c;
  assign multi_c      = capture_pt_c && any_c && !onehot_c;
  assign glyph_c      = decode_seg(seg_norm_c);

  // Dwell tracking: restart on any anode change, saturate once settled.
  always_comb begin
    an_d       = an_in;
    cnt_d      = cnt_q;
    captured_d = captured_q;
    if (!stable_c) begin
      cnt_d      = '0;
      captured_d = 1'b0;
    end else begin
      if (cnt_q < SETTLE_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (capture_pt_c) begin
        captured_d = 1'b1;
      end
    end
  end

  // Slot capture and frame bookkeeping; clear overrides both.
  always_comb begin
    digits_d     = digits_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    inv_d        = inv_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    scan_error_d = scan_error_q;
    if (valid_q == '1) begin
      valid_d      = '0;
      frame_done_d = 1'b1;
    end
    if (capture_c) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_norm_c[i]) begin
          digits_d[NIB_W*i +: NIB_W] = glyph_c.nib;
          dp_d[i]    = dp_norm_c;
          blank_d[i] = glyph_c.blank;
          inv_d[i]   = glyph_c.inv;
          valid_d[i] = 1'b1;
        end
      end
    end
    if (multi_c) begin
      scan_error_d = 1'b1;
    end
    if (clear) begin
      digits_d     = DIGITS_RST;
      dp_d         = dp_q;
      blank_d      = blank_q;
      inv_d        = inv_q;
      valid_d      = '0;
      frame_done_d = 1'b0;
      scan_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q         <= AN_IDLE;
      cnt_q        <= '0;
      captured_q   <= 1'b0;
      digits_q     <= DIGITS_RST;
      dp_q         <= '0;
      blank_q      <= '0;
      inv_q        <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
      scan_error_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      inv_q        <= inv_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      scan_error_q <= scan_error_d;
    end
  end

  assign digits      = digits_q;
  assign dp_out      = dp_q;
  assign blank       = blank_q;
  assign invalid     = inv_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign scan_error  = scan_error_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: table-driven glyph captures through a scoreboard
// queue plus directed sequences for settle boundary, multi-anode, clear and mid-frame reset.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

  localparam int unsigned ND        = 8;
  localparam int unsigned SETTLE    = 4;
  localparam int unsigned CAP_EDGES = SETTLE + 1;
  localparam int unsigned NVEC      = 14;

`ifdef SEG_DECODE_HEX_EN
  localparam logic [3:0] NIB_A   = 4'hA;
  localparam logic [3:0] NIB_B   = 4'hB;
  localparam logic       HEX_INV = 1'b0;
`else
  localparam logic [3:0] NIB_A   = 4'hF;
  localparam logic [3:0] NIB_B   = 4'hF;
  localparam logic       HEX_INV = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [ND-1:0] an_in;
  logic [6:0]    cat_in;
  logic          dp_in;
  logic          clear;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp_out;
  logic [ND-1:0] blank;
  logic [ND-1:0] invalid;
  logic [ND-1:0] digit_valid;
  logic          frame_done;
  logic          scan_error;

  seg_scan_decoder #(
    .NUM_DIGITS(ND), .SETTLE_CYCLES(SETTLE), .AN_ACTIVE_LOW(1), .CAT_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .an_in(an_in), .cat_in(cat_in), .dp_in(dp_in), .clear(clear),
    .digits(digits), .dp_out(dp_out), .blank(blank), .invalid(invalid),
    .digit_valid(digit_valid), .frame_done(frame_done), .scan_error(scan_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] nib;
    logic       blk;
    logic       inv;
  } vec_t;

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  vec_t tbl [NVEC];
  vec_t sb_q [$];
  int   errors   = 0;
  int   checks   = 0;
  int   fd_count = 0;

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int cycles);
    an_in  = '1;
    cat_in = '1;
    dp_in  = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // Hold one anode for a dwell; a long enough dwell queues its expected capture.
  task automatic dwell(input vec_t v, input int cycles);
    vec_t e;
    an_in  = ~(ND'(1) << v.slot);
    cat_in = ~v.seg;
    dp_in  = ~v.dp;
    if (cycles >= int'(CAP_EDGES)) begin
      sb_q.push_back(v);
      repeat (CAP_EDGES) @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("slot%0d_cap", e.slot),
            32'({digit_valid[e.slot], digits[4*e.slot +: 4], blank[e.slot], invalid[e.slot], dp_out[e.slot]}),
            32'({1'b1, e.nib, e.blk, e.inv, e.dp}));
      repeat (cycles - int'(CAP_EDGES)) @(negedge clk);
    end else begin
      repeat (cycles) @(negedge clk);
    end
  endtask

  task automatic full_scan();
    for (int i = 0; i < int'(ND); i++) dwell(tbl[i], 6);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_digits"}, digits, 32'hFFFF_FFFF);
    check({tag, "_vecs"}, 32'({dp_out, blank, invalid, digit_valid}), 32'h0);
    check({tag, "_flags"}, 32'({frame_done, scan_error}), 32'h0);
  endtask

  initial begin
    int   fd_before;
    vec_t v;

    for (int i = 0; i < int'(ND); i++) tbl[i] = '{i, glyph[i], 1'(i % 2), 4'(i), 1'b0, 1'b0};
    tbl[8]  = '{0, 7'h77, 1'b0, NIB_A, 1'b0, HEX_INV};
    tbl[9]  = '{0, 7'h00, 1'b1, 4'hF,  1'b1, 1'b0};
    tbl[10] = '{1, 7'h49, 1'b0, 4'hF,  1'b0, 1'b1};
    tbl[11] = '{3, 7'h7C, 1'b1, NIB_B, 1'b0, HEX_INV};
    tbl[12] = '{5, 7'h6F, 1'b0, 4'h9,  1'b0, 1'b0};
    tbl[13] = '{6, 7'h7F, 1'b0, 4'h8,  1'b0, 1'b0};

    reset = 1'b1;
    clear = 1'b0;
    idle(2);
    check_reset_values("rst");
    reset = 1'b0;
    idle(1);

    // Full scan of digits 0..7.
    full_scan();
    @(negedge clk);
    check("scan_digits", digits, 32'h7654_3210);
    check("scan_inv_blank", 32'({invalid, blank}), 32'h0);
    check("scan_dp", 32'(dp_out), 32'hAA);
    check("scan_fd_once", 32'(fd_count), 32'd1);
    check("scan_valid_cleared", 32'(digit_valid), 32'h0);

    // Decode corner glyphs, with gaps so repeated slots start fresh dwells.
    for (int i = int'(ND); i < int'(NVEC); i++) begin
      idle(2);
      dwell(tbl[i], 6);
    end
    idle(2);
    check("recap_valid", 32'(digit_valid), 32'h6B);
    check("recap_no_fd", 32'(fd_count), 32'd1);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_valid", 32'(digit_valid), 32'h0);
    check("clear_digits", digits, 32'hFFFF_FFFF);
    check("clear_holds_blank", 32'(blank), 32'h01);

    // Settle boundary: dwells of SETTLE-1 and SETTLE cycles must not capture.
    v = '{2, 7'h4F, 1'b0, 4'h3, 1'b0, 1'b0};
    dwell(v, SETTLE - 1);
    idle(3);
    check("short3_valid", 32'(digit_valid), 32'h0);
    check("short3_nib", 32'(digits[11:8]), 32'hF);
    dwell(v, SETTLE);
    idle(3);
    check("short4_valid", 32'(digit_valid), 32'h0);
    dwell(v, CAP_EDGES);
    idle(2);
    check("exact_valid", 32'(digit_valid), 32'h04);

    // Two anodes enabled together.
    an_in  = 8'b1111_1001;
    cat_in = ~7'h06;
    repeat (10) @(negedge clk);
    check("multi_err", 32'(scan_error), 32'd1);
    check("multi_no_update", digits, 32'hFFFF_F3FF);
    idle(5);
    check("multi_sticky", 32'(scan_error), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("multi_cleared", 32'({scan_error, digit_valid}), 32'h0);

    // Clear coincident with the frame-completing capture.
    fd_before = fd_count;
    for (int i = 0; i < int'(ND) - 1; i++) dwell(tbl[i], 6);
    an_in  = ~(ND'(1) << 7);
    cat_in = ~glyph[7];
    dp_in  = 1'b0;
    repeat (SETTLE) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("clrfrm_no_fd", 32'(fd_count - fd_before), 32'd0);
    check("clrfrm_valid", 32'(digit_valid), 32'h0);
    check("clrfrm_digits", digits, 32'hFFFF_FFFF);

    // Reset in the middle of a frame, then a normal frame.
    idle(2);
    for (int i = 0; i < 4; i++) dwell(tbl[i], 6);
    an_in  = ~(ND'(1) << 4);
    cat_in = ~glyph[4];
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_no_partial", 32'(digit_valid), 32'h0);
    fd_before = fd_count;
    full_scan();
    @(negedge clk);
    check("post_rst_fd", 32'(fd_count - fd_before), 32'd1);
    check("post_rst_digits", digits, 32'h7654_3210);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
